// File: rtl/gate_vec_unit_pkg.sv
// Shared definitions for gate_vec_unit: op codes and op width.
// Imported by the top; holds no logic.
package gate_vec_unit_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND  = 3'd0;
  localparam logic [OP_W-1:0] OP_NAND = 3'd1;
  localparam logic [OP_W-1:0] OP_OR   = 3'd2;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd5;
  localparam logic [OP_W-1:0] OP_NOT  = 3'd6;
  localparam logic [OP_W-1:0] OP_PASS = 3'd7;

endpackage

// File: rtl/gate_fifo.sv
// Synchronous FIFO, DW bits x DEPTH entries (DEPTH power of 2).
// Ports: clk, rst_n, push/wdata, pop/rdata, full, empty, level.
module gate_fifo #(
  parameter int DW    = 11,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DW-1:0]            wdata,
  input  logic                     pop,
  output logic [DW-1:0]            rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  // a push while full is refused even if a pop
  // happens in the same cycle
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/gate_vec_unit.sv
// Bitwise gate unit: 8 logic functions on W-bit a/b, results queued
// in a DEPTH-entry FIFO with valid/ready on both sides.
// Ports: clk, rst_n, in_valid/in_ready/a/b/op, out_valid/out_ready/
// z/z_op, level, ovf_err (sticky). Option GATE_REDUCE_EN adds
// red_and/red_or/red_xor of each result, stored per entry.
module gate_vec_unit
  import gate_vec_unit_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           a,
  input  logic [W-1:0]           b,
  input  logic [OP_W-1:0]        op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W-1:0]           z,
  output logic [OP_W-1:0]        z_op,
  output logic [$clog2(DEPTH):0] level,
`ifdef GATE_REDUCE_EN
  output logic                   red_and,
  output logic                   red_or,
  output logic                   red_xor,
`endif
  output logic                   ovf_err
);

`ifdef GATE_REDUCE_EN
  localparam int RW = 3;
`else
  localparam int RW = 0;
`endif
  localparam int EW = RW + OP_W + W;

  logic [W-1:0]  res;
  logic [EW-1:0] wentry;
  logic [EW-1:0] rentry;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  always_comb begin
    res = '0;
    unique case (op)
      OP_AND:  res = a & b;
      OP_NAND: res = ~(a & b);
      OP_OR:   res = a | b;
      OP_NOR:  res = ~(a | b);
      OP_XOR:  res = a ^ b;
      OP_XNOR: res = ~(a ^ b);
      OP_NOT:  res = ~a;
      OP_PASS: res = a;
      default: res = '0;
    endcase
  end

`ifdef GATE_REDUCE_EN
  assign wentry = {&res, |res, ^res, op, res};
  assign red_and = rentry[EW-1];
  assign red_or  = rentry[EW-2];
  assign red_xor = rentry[EW-3];
`else
  assign wentry = {op, res};
`endif

  assign z    = rentry[W-1:0];
  assign z_op = rentry[W +: OP_W];

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_err <= 1'b0;
    end else if (in_valid && !in_ready) begin
      ovf_err <= 1'b1;
    end
  end

  gate_fifo #(
    .DW    (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wentry),
    .pop   (pop),
    .rdata (rentry),
    .full  (full),
    .empty (empty),
    .level (level)
  );

endmodule

// File: tb/tb_gate_vec_unit.sv
// Self-checking bench for gate_vec_unit (W=8, DEPTH=4) against a
// queue-based reference model.
module tb_gate_vec_unit;

  localparam int W     = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [2:0] op = '0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] z;
  logic [2:0] z_op;
  logic [2:0] level;
  logic       ovf_err;
`ifdef GATE_REDUCE_EN
  logic       red_and;
  logic       red_or;
  logic       red_xor;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] op;
    logic [7:0] z;
  } ent_t;

  ent_t q[$];
  bit   m_ovf = 1'b0;

  always #5 clk = ~clk;

  gate_vec_unit #(.W(W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .z_op      (z_op),
    .level     (level),
`ifdef GATE_REDUCE_EN
    .red_and   (red_and),
    .red_or    (red_or),
    .red_xor   (red_xor),
`endif
    .ovf_err   (ovf_err)
  );

  function automatic logic [7:0] gate_ref(
    input logic [2:0] o,
    input logic [7:0] x,
    input logic [7:0] y
  );
    logic [7:0] r;
    case (o)
      3'd0:    r = x & y;
      3'd1:    r = 8'hFF - (x & y);
      3'd2:    r = x | y;
      3'd3:    r = 8'hFF - (x | y);
      3'd4:    r = x ^ y;
      3'd5:    r = 8'hFF - (x ^ y);
      3'd6:    r = 8'hFF - x;
      default: r = x;
    endcase
    return r;
  endfunction

  // advance one clock, apply the model, settle 1 time unit
  task automatic step();
    bit   full;
    bit   pp;
    ent_t e;
    @(posedge clk);
    full = (q.size() == DEPTH);
    pp   = (q.size() > 0) && out_ready;
    if (in_valid && full) m_ovf = 1'b1;
    if (pp) void'(q.pop_front());
    if (in_valid && !full) begin
      e.op = op;
      e.z  = gate_ref(op, a, b);
      q.push_back(e);
    end
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < DEPTH + 1; k++) begin
      if (q.size() > 0) step();
    end
    out_ready = 1'b0;
    checks++;
    if (level !== 3'd0) begin
      errors++;
      $display("FAIL drain_level got %0d want 0", level);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks += 6;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_in_ready got %b want 1", in_ready);
    end
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_out_valid got %b want 0", out_valid);
    end
    if (level !== 3'd0) begin
      errors++; $display("FAIL rst_level got %0d want 0", level);
    end
    if (z !== 8'h00) begin
      errors++; $display("FAIL rst_z got %h want 00", z);
    end
    if (z_op !== 3'd0) begin
      errors++; $display("FAIL rst_z_op got %0d want 0", z_op);
    end
    if (ovf_err !== 1'b0) begin
      errors++; $display("FAIL rst_ovf got %b want 0", ovf_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    m_ovf = 1'b0;
  endtask

  task automatic test_ops();
    logic [7:0] exp_z [8];
    exp_z = '{8'hC0, 8'h3F, 8'hFC, 8'h03,
              8'h3C, 8'hC3, 8'h0F, 8'hF0};
    a = 8'hF0;
    b = 8'hCC;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      op = 3'(i);
      step();
      checks += 3;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL ops_valid[%0d] got %b want 1", i, out_valid);
      end
      if (z !== exp_z[i]) begin
        errors++;
        $display("FAIL ops_z[%0d] got %h want %h", i, z, exp_z[i]);
      end
      if (z_op !== 3'(i)) begin
        errors++;
        $display("FAIL ops_zop[%0d] got %0d want %0d", i, z_op, i);
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL ops_empty got %b want 0", out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_full();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a  = 8'($urandom);
      b  = 8'($urandom);
      op = 3'($urandom);
      step();
      checks += 2;
      if (in_ready !== (i < 3)) begin
        errors++;
        $display("FAIL full_in_ready[%0d] got %b want %b",
                 i, in_ready, (i < 3));
      end
      if (level !== 3'(q.size())) begin
        errors++;
        $display("FAIL full_level[%0d] got %0d want %0d",
                 i, level, q.size());
      end
    end
    in_valid = 1'b0;
    checks += 2;
    if (ovf_err !== 1'b1) begin
      errors++; $display("FAIL full_ovf got %b want 1", ovf_err);
    end
    if (level !== 3'd4) begin
      errors++; $display("FAIL full_level4 got %0d want 4", level);
    end
  endtask

  task automatic test_full_pop();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    a  = 8'($urandom);
    op = 3'd7;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks += 3;
    if (level !== 3'd3) begin
      errors++; $display("FAIL fpop_level got %0d want 3", level);
    end
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL fpop_in_ready got %b want 1", in_ready);
    end
    if (z !== q[0].z) begin
      errors++; $display("FAIL fpop_z got %h want %h", z, q[0].z);
    end
  endtask

  task automatic test_stream();
    drain();
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a  = 8'($urandom);
      b  = 8'($urandom);
      op = 3'($urandom);
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a  = 8'($urandom);
      b  = 8'($urandom);
      op = 3'($urandom);
      step();
      checks += 3;
      if (level !== 3'd2) begin
        errors++;
        $display("FAIL strm_level[%0d] got %0d want 2", i, level);
      end
      if (z !== q[0].z) begin
        errors++;
        $display("FAIL strm_z[%0d] got %h want %h", i, z, q[0].z);
      end
      if (z_op !== q[0].op) begin
        errors++;
        $display("FAIL strm_zop[%0d] got %0d want %0d",
                 i, z_op, q[0].op);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      a  = 8'($urandom);
      b  = 8'($urandom);
      op = 3'($urandom);
      step();
      checks += 4;
      if (level !== 3'(q.size())) begin
        errors++;
        $display("FAIL rnd_level[%0d] got %0d want %0d",
                 i, level, q.size());
      end
      if (out_valid !== (q.size() > 0)) begin
        errors++;
        $display("FAIL rnd_valid[%0d] got %b", i, out_valid);
      end
      if (in_ready !== (q.size() < DEPTH)) begin
        errors++;
        $display("FAIL rnd_ready[%0d] got %b", i, in_ready);
      end
      if (ovf_err !== m_ovf) begin
        errors++;
        $display("FAIL rnd_ovf[%0d] got %b want %b",
                 i, ovf_err, m_ovf);
      end
      if (q.size() > 0) begin
        checks += 2;
        if (z !== q[0].z) begin
          errors++;
          $display("FAIL rnd_z[%0d] got %h want %h", i, z, q[0].z);
        end
        if (z_op !== q[0].op) begin
          errors++;
          $display("FAIL rnd_zop[%0d] got %0d want %0d",
                   i, z_op, q[0].op);
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    drain();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a  = 8'hA5 ^ 8'(i);
      b  = 8'($urandom);
      op = 3'd7;
      step();
    end
    in_valid = 1'b1;
    checks++;
    if (level !== 3'd3) begin
      errors++; $display("FAIL mid_pre_level got %0d want 3", level);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks += 6;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL mid_valid got %b want 0", out_valid);
    end
    if (level !== 3'd0) begin
      errors++; $display("FAIL mid_level got %0d want 0", level);
    end
    if (z !== 8'h00) begin
      errors++; $display("FAIL mid_z got %h want 00", z);
    end
    if (z_op !== 3'd0) begin
      errors++; $display("FAIL mid_zop got %0d want 0", z_op);
    end
    if (ovf_err !== 1'b0) begin
      errors++; $display("FAIL mid_ovf got %b want 0", ovf_err);
    end
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL mid_ready got %b want 1", in_ready);
    end
    q.delete();
    m_ovf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1;
    a  = 8'h5A;
    op = 3'd7;
    step();
    in_valid = 1'b0;
    checks += 2;
    if (z !== 8'h5A) begin
      errors++; $display("FAIL post_rst_z got %h want 5a", z);
    end
    if (level !== 3'd1) begin
      errors++; $display("FAIL post_rst_level got %0d want 1", level);
    end
  endtask

`ifdef GATE_REDUCE_EN
  task automatic test_reduce();
    drain();
    a = 8'hFF;
    b = 8'hFF;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    op = 3'd0;
    step();
    checks += 3;
    if (red_and !== 1'b1) begin
      errors++; $display("FAIL red_and_and got %b want 1", red_and);
    end
    if (red_or !== 1'b1) begin
      errors++; $display("FAIL red_and_or got %b want 1", red_or);
    end
    if (red_xor !== 1'b0) begin
      errors++; $display("FAIL red_and_xor got %b want 0", red_xor);
    end
    op = 3'd4;
    step();
    checks += 3;
    if (red_and !== 1'b0) begin
      errors++; $display("FAIL red_xor_and got %b want 0", red_and);
    end
    if (red_or !== 1'b0) begin
      errors++; $display("FAIL red_xor_or got %b want 0", red_or);
    end
    if (red_xor !== 1'b0) begin
      errors++; $display("FAIL red_xor_xor got %b want 0", red_xor);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_ops();
    test_full();
    test_full_pop();
    test_stream();
    test_random();
    test_reset_mid();
`ifdef GATE_REDUCE_EN
    test_reduce();
`endif
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
